mult_norm_seq: RTL and testbench

- Front end of the FP multiplier datapath and producer of the rounding-stage interface.
- Accepts two IEEE-754 single-precision operands over a valid/ready handshake.
- Multiplies the 24-bit significands with an iterative radix-2 shift-add engine, then normalizes the 48-bit product.
- Presents norm_exponent, norm_mantissa, guard, sticky and sign, registered and held under valid/ready, for the rounding stage.

---
 rtl/fp_mult_pkg.sv | 7 +
 rtl/prod_normalize.sv | 23 ++
 rtl/mult_norm_seq.sv | 121 ++++++++++++
 tb/tb_mult_norm_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared constants and FSM state type for the FP multiplier front end
package fp_mult_pkg;
  localparam int DEF_BIAS = 127;
  localparam int DEF_MW = 24;
  localparam int EW = 10;
  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} mult_state_t;
endpackage

// File: rtl/prod_normalize.sv
// prod_normalize: aligns the double-width product so its leading one lands in the mantissa MSB
module prod_normalize
  import fp_mult_pkg::*;
#(
  parameter int MW = DEF_MW
) (
  input  logic [2*MW-1:0] p,
  input  logic [EW-1:0]   exp_in,
  output logic [MW-1:0]   mant,
  output logic            guard,
  output logic            sticky,
  output logic [EW-1:0]   exp_out
);
  logic top;
  // a product of two [1,2) significands lies in [1,4); the top bit picks the one-bit shift
  always_comb begin
    top = p[2*MW-1];
    mant = top ? p[2*MW-1:MW] : p[2*MW-2:MW-1];
    guard = top ? p[MW-1] : p[MW-2];
    sticky = top ? |p[MW-2:0] : |p[MW-3:0];
    exp_out = top ? exp_in + 1'b1 : exp_in;
  end
endmodule

// File: rtl/mult_norm_seq.sv
// mult_norm_seq: iterative shift-add significand multiplier with normalized, handshaked output
module mult_norm_seq
  import fp_mult_pkg::*;
#(
  parameter int BIAS = DEF_BIAS,
  parameter int MW = DEF_MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] norm_exponent,
  output logic [MW-1:0] norm_mantissa,
  output logic          guard,
  output logic          sticky,
  output logic          sign
);
  localparam int CW = $clog2(MW);
  mult_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*MW-1:0] p_q, p_d;
  logic [MW-1:0] ma_q, ma_d, mb_q, mb_d, mant_q, mant_d, n_mant;
  logic [EW-1:0] esum_q, esum_d, exp_q, exp_d, n_exp;
  logic sign_q, sign_d, guard_q, guard_d, sticky_q, sticky_d, ov_q, ov_d, n_guard, n_sticky;

  prod_normalize #(.MW(MW)) u_norm (
    .p(p_q),
    .exp_in(esum_q),
    .mant(n_mant),
    .guard(n_guard),
    .sticky(n_sticky),
    .exp_out(n_exp)
  );

  // next-state, shift-add step and output capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    ma_d = ma_q;
    mb_d = mb_q;
    esum_d = esum_q;
    sign_d = sign_q;
    mant_d = mant_q;
    exp_d = exp_q;
    guard_d = guard_q;
    sticky_d = sticky_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = a[31] ^ b[31];
        esum_d = {2'b0, a[30:23]} + {2'b0, b[30:23]} - EW'(BIAS);
        ma_d = {|a[30:23], a[22:0]};
        mb_d = {|b[30:23], b[22:0]};
        p_d = '0;
        cnt_d = '0;
        state_d = MULT;
      end
      MULT: begin
        p_d = p_q + (mb_q[cnt_q] ? ({{MW{1'b0}}, ma_q} << cnt_q) : '0);
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(MW - 1) ? NORM : MULT;
      end
      NORM: begin
        mant_d = n_mant;
        exp_d = n_exp;
        guard_d = n_guard;
        sticky_d = n_sticky;
        ov_d = 1'b1;
        state_d = DONE;
      end
      default: if (out_ready) begin
        ov_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      esum_q <= '0;
      sign_q <= 1'b0;
      mant_q <= '0;
      exp_q <= '0;
      guard_q <= 1'b0;
      sticky_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      esum_q <= esum_d;
      sign_q <= sign_d;
      mant_q <= mant_d;
      exp_q <= exp_d;
      guard_q <= guard_d;
      sticky_q <= sticky_d;
      ov_q <= ov_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign out_valid = ov_q;
  assign norm_mantissa = mant_q;
  assign norm_exponent = exp_q;
  assign guard = guard_q;
  assign sticky = sticky_q;
  assign sign = sign_q;
endmodule

// File: tb/tb_mult_norm_seq.sv
// tb_mult_norm_seq: directed-vector self-checking bench for mult_norm_seq
module tb_mult_norm_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, guard, sticky, sign;
  logic [9:0] norm_exponent;
  logic [23:0] norm_mantissa;
  int n_chk = 0;
  int n_pass = 0;

  mult_norm_seq dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .norm_exponent(norm_exponent),
    .norm_mantissa(norm_mantissa),
    .guard(guard),
    .sticky(sticky),
    .sign(sign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("latency", 32'(cyc), 32'd25);
  endtask

  task automatic check_result(input logic [23:0] m, input logic [9:0] e, input logic g, input logic s, input logic sg);
    check("mant", 32'(norm_mantissa), 32'(m));
    check("exp", 32'(norm_exponent), 32'(e));
    check("guard", 32'(guard), 32'(g));
    check("sticky", 32'(sticky), 32'(s));
    check("sign", 32'(sign), 32'(sg));
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic [23:0] m, input logic [9:0] e, input logic g, input logic s, input logic sg);
    start(va, vb);
    wait_result();
    check_result(m, e, g, s, sg);
    drain();
  endtask

  initial begin
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mant", 32'(norm_mantissa), 32'd0);
    check("rst_exp", 32'(norm_exponent), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    run_op(32'h3FC00000, 32'h40000000, 24'hC00000, 10'h080, 1'b0, 1'b0, 1'b0);
    run_op(32'h3FC00000, 32'h3FC00000, 24'h900000, 10'h080, 1'b0, 1'b0, 1'b0);
    run_op(32'h3F800001, 32'h3FC00000, 24'hC00001, 10'h07F, 1'b1, 1'b0, 1'b0);
    run_op(32'h3F800001, 32'h3F800001, 24'h800002, 10'h07F, 1'b0, 1'b1, 1'b0);
    run_op(32'h80000000, 32'h3F800000, 24'h000000, 10'h000, 1'b0, 1'b0, 1'b1);
    run_op(32'h00800000, 32'h00800000, 24'h800000, 10'h383, 1'b0, 1'b0, 1'b0);
    start(32'hBFC00000, 32'h40000000);
    wait_result();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 32'h3F800001 + 32'(i);
      in_valid = i[0];
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check_result(24'hC00000, 10'h080, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    start(32'h3FC00000, 32'h3FC00000);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_mant", 32'(norm_mantissa), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);
    end
    run_op(32'h3F800001, 32'h3FC00000, 24'hC00001, 10'h07F, 1'b1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
